// File: rtl/aes_pkg.sv
// Shared AES types, constants, inverse S-box table and GF(2^8) helpers.
// Used by both aes_decipher and aes_encipher.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  localparam logic [3:0] NR_AES128 = 4'd10;
  localparam logic [3:0] NR_AES192 = 4'd12;
  localparam logic [3:0] NR_AES256 = 4'd14;

  // Entry i lives at bits [2047-8i -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic byte_t gf_mul2(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(byte_t b, byte_t c);
    byte_t p;
    byte_t a;
    p = '0;
    a = b;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) p = p ^ a;
      a = gf_mul2(a);
    end
    return p;
  endfunction

  function automatic state_t inv_shift_rows(state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic state_t inv_mix_columns(state_t s);
    state_t o;
    byte_t a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                       ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                       ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                       ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                       ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Single-byte AES inverse S-box, pure combinational lookup.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  byte_t a,
  output byte_t y
);

  logic [10:0] base;

  assign base = 11'd2047 - {a, 3'b000};
  assign y    = INV_SBOX[base -: 8];

endmodule

// File: rtl/aes_decipher.sv
// Iterative AES inverse cipher, one round per clock, keys from shared expansion.
// Define AES_DEC_PARAM_CHK_EN to add the err output and round_num checking.
module aes_decipher
  import aes_pkg::*;
#(
  parameter int MAX_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         next,
  input  logic         key_ready,
  input  logic [3:0]   round_num,
  input  logic [127:0] round_key,
  output logic [3:0]   round,
  input  logic [127:0] cipher,
  output logic [127:0] plain,
  output logic         ready,
  output logic         valid
`ifdef AES_DEC_PARAM_CHK_EN
  ,
  output logic         err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL
  } fsm_t;

  fsm_t       state;
  state_t     block;
  state_t     shifted;
  state_t     subbed;
  state_t     keyed;
  state_t     mixed;
  logic [3:0] nr;
  logic       accept;

  assign ready   = (state == IDLE) & key_ready;
  assign shifted = inv_shift_rows(block);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .a (shifted[127-8*i -: 8]),
      .y (subbed[127-8*i -: 8])
    );
  end

  assign keyed = subbed ^ round_key;
  assign mixed = inv_mix_columns(keyed);

`ifdef AES_DEC_PARAM_CHK_EN
  logic bad;

  assign bad = !(round_num inside {NR_AES128, NR_AES192, NR_AES256})
             || (int'(round_num) > MAX_ROUNDS);
  assign accept = next & ready & ~bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= next & (~ready | bad);
    end
  end
`else
  assign accept = next & ready;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      round <= '0;
      block <= '0;
      plain <= '0;
      valid <= 1'b0;
      nr    <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            block <= cipher;
            nr    <= round_num;
            round <= round_num;
            state <= INIT;
          end
        end
        INIT: begin
          block <= block ^ round_key;
          round <= round - 4'd1;
          // Degenerate Nr<=1 has no middle rounds at all.
          state <= (nr > 4'd1) ? ROUND : FINAL;
        end
        ROUND: begin
          block <= mixed;
          round <= round - 4'd1;
          if (round == 4'd1) state <= FINAL;
        end
        FINAL: begin
          block <= keyed;
          plain <= keyed;
          valid <= 1'b1;
          round <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decipher.sv
// Self-checking bench for aes_decipher: key-schedule model, forward
// reference cipher and a cycle-level transaction model.
module tb_aes_decipher;

  localparam logic [255:0] K128 =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] LB_P = 128'h010203040506070809101112131415;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         next;
  logic         key_ready;
  logic [3:0]   round_num;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic [127:0] cipher;
  logic [127:0] plain;
  logic         ready;
  logic         valid;
`ifdef AES_DEC_PARAM_CHK_EN
  logic         err;
`endif

  always #5 clk = ~clk;

  aes_decipher #(.MAX_ROUNDS(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .next      (next),
    .key_ready (key_ready),
    .round_num (round_num),
    .round_key (round_key),
    .round     (round),
    .cipher    (cipher),
    .plain     (plain),
    .ready     (ready),
    .valid     (valid)
`ifdef AES_DEC_PARAM_CHK_EN
    ,
    .err       (err)
`endif
  );

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk [15];
  logic [127:0] exp_plain;
  logic [127:0] lb_c;

  assign round_key = rk[round];

  task automatic chk(string name, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from its definition: GF inverse then affine map.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic void expand(logic [255:0] key, int nk, int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < 15; i++) rk[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] enc(logic [127:0] p, int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      s[i] = p[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          t[q+4*c] = s[q+4*((c+q)%4)];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          if (r != nr)
            s[q+4*c] = gm(t[q+4*c], 8'h02) ^ gm(t[(q+1)%4+4*c], 8'h03)
                     ^ t[(q+2)%4+4*c] ^ t[(q+3)%4+4*c];
          else
            s[q+4*c] = t[q+4*c];
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ rk[r][127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

`ifdef AES_DEC_PARAM_CHK_EN
  function automatic bit bad_nr(logic [3:0] n);
    return !(n == 4'd10 || n == 4'd12 || n == 4'd14);
  endfunction
`endif

  // Transaction model: accept, Nr+1 edges of work, then one valid cycle.
  bit           live   = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_rdy;
  int           m_k    = 0;
  int           m_nr   = 0;
  logic [127:0] m_pend = '0;
  logic [127:0] plain_e = '0;
  logic         valid_e = 1'b0;
  logic [3:0]   rnd_e   = '0;
  logic         err_e   = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      live    = 1'b1;
      m_busy  = 1'b0;
      plain_e = '0;
      valid_e = 1'b0;
      rnd_e   = '0;
      err_e   = 1'b0;
    end else begin
      m_rdy   = !m_busy && key_ready;
      valid_e = 1'b0;
      err_e   = 1'b0;
      if (m_busy) begin
        m_k++;
        if (m_k == m_nr + 1) begin
          m_busy  = 1'b0;
          valid_e = 1'b1;
          plain_e = m_pend;
          rnd_e   = '0;
        end else begin
          rnd_e = 4'(m_nr - m_k);
        end
      end else if (next && key_ready
`ifdef AES_DEC_PARAM_CHK_EN
                   && !bad_nr(round_num)
`endif
                  ) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_nr   = int'(round_num);
        rnd_e  = round_num;
        m_pend = exp_plain;
      end
`ifdef AES_DEC_PARAM_CHK_EN
      err_e = next && (!m_rdy || bad_nr(round_num));
`endif
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("valid", valid, valid_e);
      chk("ready", ready, !m_busy && key_ready);
      chk("round", round, rnd_e);
      chk("plain", plain, plain_e);
`ifdef AES_DEC_PARAM_CHK_EN
      chk("err", err, err_e);
`endif
    end
  end

  always @(negedge clk) if (valid === 1'b1) vcnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(logic [127:0] c, logic [127:0] p, logic [3:0] n);
    cipher    = c;
    exp_plain = p;
    round_num = n;
    next      = 1'b1;
    tick();
    next      = 1'b0;
  endtask

  task automatic pulse();
    next = 1'b1;
    tick();
    next = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int v0;
    rst_n     = 1'b0;
    next      = 1'b0;
    key_ready = 1'b1;
    round_num = 4'd10;
    cipher    = '0;
    exp_plain = '0;

    build_sbox();
    chk("sbox_00", sb[8'h00], 8'h63);
    chk("sbox_53", sb[8'h53], 8'hed);
    expand(K256, 8, 14);
    chk("model_c3", enc(PT, 14), C3);
    expand(K128, 4, 10);
    chk("model_c1", enc(PT, 10), C1);
    lb_c = enc(LB_P, 10);

    tick();
    tick();
    rst_n = 1'b1;
    tick();

    start(C1, PT, 4'd10);
    wait_valid(40, n);
    chk("c1_latency", n, 11);
    chk("c1_plain", plain, PT);

    start(lb_c, LB_P, 4'd10);
    wait_valid(40, n);
    chk("b2b_gap", n + 1, 12);
    chk("lb_plain", plain, LB_P);
    tick();

    expand(K256, 8, 14);
    start(C3, PT, 4'd14);
    wait_valid(40, n);
    chk("c3_latency", n, 15);
    chk("c3_plain", plain, PT);
    tick();
    expand(K128, 4, 10);

    v0 = vcnt;
    key_ready = 1'b0;
    pulse();
    tick();
    tick();
    key_ready = 1'b1;
    tick();
    chk("kr0_no_valid", vcnt - v0, 0);

    v0 = vcnt;
    start(C1, PT, 4'd10);
    repeat (3) tick();
    pulse();
    wait_valid(40, n);
    repeat (15) tick();
    chk("busy_one_valid", vcnt - v0, 1);

`ifdef AES_DEC_PARAM_CHK_EN
    v0 = vcnt;
    round_num = 4'd5;
    pulse();
    repeat (20) tick();
    chk("nr5_rejected", vcnt - v0, 0);
    round_num = 4'd10;
`endif

    v0 = vcnt;
    start(C1, PT, 4'd10);
    n = 0;
    while (round !== 4'd6 && n < 40) begin
      tick();
      n++;
    end
    chk("reach_r6", round, 4'd6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("rst_no_valid", vcnt - v0, 0);

    start(C1, PT, 4'd10);
    wait_valid(40, n);
    chk("post_rst_lat", n, 11);
    chk("post_rst_plain", plain, PT);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
